// File: rtl/rs232_cmd_pkg.sv
// Shared constants, FSM state type and helpers for the RS232 debug command decoder.
package rs232_cmd_pkg;

  localparam logic [7:0] HDR   = 8'hA5;
  localparam logic [7:0] OP_WR = 8'h01;
  localparam logic [7:0] OP_RD = 8'h02;
  localparam logic [7:0] ACK   = 8'h06;
  localparam logic [7:0] NAK   = 8'h15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_OP,
    ST_GET_ADDR,
    ST_GET_DATA,
    ST_GET_SUM,
    ST_EXEC,
    ST_RESP
  } state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/cmd_interval_timer.sv
// Down-counting interval timer: load a value, count to zero, report expiry while at zero.
module cmd_interval_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         count,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (count && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/rs232_cmd_decoder.sv
// Parses framed read/write packets from the RS232 receiver, owns the debug register
// bank and error counter, and issues one response byte per packet to the transmitter.
module rs232_cmd_decoder
  import rs232_cmd_pkg::*;
#(
  parameter int unsigned NREGS   = 16,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned TIMEOUT = 4096,
  parameter int unsigned TX_GAP  = 64
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [7:0]           RXByte,
  input  logic                 RXStrobe,
  output logic [7:0]           TXByte,
  output logic                 TXStrobe,
  output logic [8*NREGS-1:0]   RegFile,
  output logic                 WriteStrobe,
  output logic [ADDR_W-1:0]    WriteAddr,
  output logic [7:0]           ErrCount
);

  localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);
  localparam int unsigned GAP_W = $clog2(TX_GAP + 1);

  state_e              state_q, state_d;
  logic [7:0]          op_q, op_d, addr_q, addr_d, data_q, data_d, sum_q, sum_d;
  logic [7:0]          regs_q [NREGS];
  logic [7:0]          regs_d [NREGS];
  logic [7:0]          tx_byte_q, tx_byte_d, err_cnt_q, err_cnt_d;
  logic                tx_strobe_q, tx_strobe_d, wr_strobe_q, wr_strobe_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d, idx;
  logic                in_get, to_load, to_expired, gap_load, gap_expired;
  logic                sum_ok, op_ok, addr_ok;

  assign in_get   = (state_q == ST_GET_OP) || (state_q == ST_GET_ADDR) ||
                    (state_q == ST_GET_DATA) || (state_q == ST_GET_SUM);
  assign to_load  = RXStrobe && (in_get || ((state_q == ST_IDLE) && (RXByte == HDR)));
  assign gap_load = (state_q == ST_EXEC);
  assign idx      = addr_q[ADDR_W-1:0];
  assign sum_ok   = (sum_q == (op_q ^ addr_q ^ ((op_q == OP_WR) ? data_q : 8'h00)));
  assign op_ok    = (op_q == OP_WR) || (op_q == OP_RD);
  assign addr_ok  = ({1'b0, addr_q} < 9'(NREGS));

  // Loaded with N-1 so expiry lands after exactly N cycles in the waiting state.
  cmd_interval_timer #(.W(TO_W)) u_byte_timeout (
    .clk(CLK), .rst(RST), .load(to_load), .count(1'b1),
    .load_val(TO_W'(TIMEOUT - 1)), .expired(to_expired)
  );

  cmd_interval_timer #(.W(GAP_W)) u_tx_gap (
    .clk(CLK), .rst(RST), .load(gap_load), .count(1'b1),
    .load_val(GAP_W'(TX_GAP - 1)), .expired(gap_expired)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    data_d      = data_q;
    sum_d       = sum_q;
    regs_d      = regs_q;
    tx_byte_d   = tx_byte_q;
    tx_strobe_d = 1'b0;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    err_cnt_d   = err_cnt_q;
    case (state_q)
      ST_IDLE:     if (RXStrobe && (RXByte == HDR)) state_d = ST_GET_OP;
      ST_GET_OP:   if (RXStrobe) begin op_d = RXByte; state_d = ST_GET_ADDR; end
      ST_GET_ADDR: if (RXStrobe) begin
        addr_d  = RXByte;
        state_d = (op_q == OP_WR) ? ST_GET_DATA : ST_GET_SUM;
      end
      ST_GET_DATA: if (RXStrobe) begin data_d = RXByte; state_d = ST_GET_SUM; end
      ST_GET_SUM:  if (RXStrobe) begin sum_d = RXByte; state_d = ST_EXEC; end
      ST_EXEC: begin
        tx_strobe_d = 1'b1;
        state_d     = ST_RESP;
        if (sum_ok && op_ok && addr_ok) begin
          if (op_q == OP_WR) begin
            regs_d[idx] = data_q;
            wr_strobe_d = 1'b1;
            wr_addr_d   = idx;
            tx_byte_d   = ACK;
          end else begin
            tx_byte_d   = regs_q[idx];
          end
        end else begin
          tx_byte_d = NAK;
          err_cnt_d = sat_inc8(err_cnt_q);
        end
      end
      ST_RESP:     if (gap_expired) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
    // A byte arriving on the expiry cycle takes priority over the timeout.
    if (in_get && !RXStrobe && to_expired) begin
      state_d   = ST_IDLE;
      err_cnt_d = sat_inc8(err_cnt_q);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      sum_q       <= '0;
      regs_q      <= '{default: '0};
      tx_byte_q   <= '0;
      tx_strobe_q <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      sum_q       <= sum_d;
      regs_q      <= regs_d;
      tx_byte_q   <= tx_byte_d;
      tx_strobe_q <= tx_strobe_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  always_comb begin
    RegFile = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      RegFile[8*i +: 8] = regs_q[i];
    end
  end

  assign TXByte      = tx_byte_q;
  assign TXStrobe    = tx_strobe_q;
  assign WriteStrobe = wr_strobe_q;
  assign WriteAddr   = wr_addr_q;
  assign ErrCount    = err_cnt_q;

endmodule

// File: tb/tb_rs232_cmd_decoder.sv
// Bench for rs232_cmd_decoder: vector table, hand-written corner sequences and random packets vs a packet-level model.
module tb_rs232_cmd_decoder;
  localparam int unsigned NREGS = 16, ADDR_W = 4, TIMEOUT = 40, TX_GAP = 16;

  logic                CLK = 1'b0, RST = 1'b1, RXStrobe = 1'b0;
  logic [7:0]          RXByte = '0;
  logic [7:0]          TXByte, ErrCount;
  logic                TXStrobe, WriteStrobe;
  logic [8*NREGS-1:0]  RegFile;
  logic [ADDR_W-1:0]   WriteAddr;

  rs232_cmd_decoder #(.NREGS(NREGS), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .TX_GAP(TX_GAP)) dut (
    .CLK(CLK), .RST(RST), .RXByte(RXByte), .RXStrobe(RXStrobe), .TXByte(TXByte),
    .TXStrobe(TXStrobe), .RegFile(RegFile), .WriteStrobe(WriteStrobe),
    .WriteAddr(WriteAddr), .ErrCount(ErrCount)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [0:4][7:0] b;
    int              n;
    logic [7:0]      exp_tx;
    int              exp_wr;
  } vec_t;

  int n_cmp = 0, n_bad = 0, cyc = 0, tx_n = 0, tx_cyc = -100, wr_n = 0;
  logic [7:0] tx_last = '0;
  logic [7:0] model_regs [NREGS];
  int model_err = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge CLK);
    #1;
    cyc++;
    if (TXStrobe === 1'b1) begin tx_n++; tx_last = TXByte; tx_cyc = cyc; end
    if (WriteStrobe === 1'b1) wr_n++;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic send_byte(input logic [7:0] b);
    RXByte = b; RXStrobe = 1'b1;
    step();
    RXStrobe = 1'b0; RXByte = 8'($urandom);
  endtask

  task automatic send_pkt(input logic [0:4][7:0] b, input int n, input int gap,
                          output int got_tx, output logic [7:0] got_byte, output int got_wr);
    int tx0, wr0, c_sum;
    tx0 = tx_n; wr0 = wr_n;
    for (int i = 0; i < n; i++) begin
      send_byte(b[i]);
      if (i < n - 1) idle((gap < 0) ? int'($urandom_range(0, 3)) : gap);
    end
    c_sum = cyc;
    idle(TX_GAP + 2);
    got_tx = tx_n - tx0; got_byte = tx_last; got_wr = wr_n - wr0;
    if (got_tx == 1) begin
      chk("tx_latency", 128'(tx_cyc - c_sum), 128'd1);
      chk("tx_hold", TXByte, got_byte);
    end
  endtask

  // Packet-level reference: decide the response from the framing rules alone.
  function automatic logic [7:0] model_pkt(input logic [7:0] op, addr, data, sum, output int wr);
    logic [7:0] want;
    want = (op == 8'h01) ? (op ^ addr ^ data) : (op ^ addr);
    wr = 0;
    if (sum == want && (op == 8'h01 || op == 8'h02) && int'(addr) < NREGS) begin
      if (op == 8'h01) begin
        model_regs[addr] = data; wr = 1;
        return 8'h06;
      end
      return model_regs[addr];
    end
    if (model_err < 255) model_err++;
    return 8'h15;
  endfunction

  function automatic logic [8*NREGS-1:0] model_flat();
    logic [8*NREGS-1:0] f;
    for (int i = 0; i < NREGS; i++) f[8*i +: 8] = model_regs[i];
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) model_regs[i] = 8'h00;
    model_err = 0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_regfile"}, RegFile, '0);
    chk({tag, "_txbyte"}, TXByte, 8'h00);
    chk({tag, "_txstrobe"}, TXStrobe, 1'b0);
    chk({tag, "_wrstrobe"}, WriteStrobe, 1'b0);
    chk({tag, "_wraddr"}, WriteAddr, '0);
    chk({tag, "_errcount"}, ErrCount, 8'h00);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [10];
    int got_tx, got_wr, tx0, exp_wr, n_nak;
    logic [7:0] got_b, exp_b, op, addr, data, sum;
    logic [0:4][7:0] pk;

    tbl[0] = '{b:{8'hA5, 8'h01, 8'h03, 8'h5C, 8'h5E}, n:5, exp_tx:8'h06, exp_wr:1};
    tbl[1] = '{b:{8'hA5, 8'h02, 8'h03, 8'h01, 8'h00}, n:4, exp_tx:8'h5C, exp_wr:0};
    tbl[2] = '{b:{8'hA5, 8'h01, 8'h03, 8'h5C, 8'h00}, n:5, exp_tx:8'h15, exp_wr:0};
    tbl[3] = '{b:{8'hA5, 8'h02, 8'h03, 8'h01, 8'h00}, n:4, exp_tx:8'h5C, exp_wr:0};
    tbl[4] = '{b:{8'hA5, 8'h01, 8'h0F, 8'hC3, 8'hCD}, n:5, exp_tx:8'h06, exp_wr:1};
    tbl[5] = '{b:{8'hA5, 8'h02, 8'h0F, 8'h0D, 8'h00}, n:4, exp_tx:8'hC3, exp_wr:0};
    tbl[6] = '{b:{8'hA5, 8'h01, 8'h10, 8'h77, 8'h66}, n:5, exp_tx:8'h15, exp_wr:0};
    tbl[7] = '{b:{8'hA5, 8'h07, 8'h03, 8'h04, 8'h00}, n:4, exp_tx:8'h15, exp_wr:0};
    tbl[8] = '{b:{8'hA5, 8'h02, 8'h14, 8'h16, 8'h00}, n:4, exp_tx:8'h15, exp_wr:0};
    tbl[9] = '{b:{8'hA5, 8'h02, 8'h00, 8'h02, 8'h00}, n:4, exp_tx:8'h00, exp_wr:0};

    model_reset();
    RST = 1'b1;
    idle(3);
    check_reset_state("reset");
    RST = 1'b0;
    idle(2);

    for (int t = 0; t < 10; t++) begin
      send_pkt(tbl[t].b, tbl[t].n, -1, got_tx, got_b, got_wr);
      chk($sformatf("tbl%0d_txcount", t), got_tx, 1);
      chk($sformatf("tbl%0d_txbyte", t), got_b, tbl[t].exp_tx);
      chk($sformatf("tbl%0d_wrcount", t), got_wr, tbl[t].exp_wr);
      if (tbl[t].exp_wr == 1) chk($sformatf("tbl%0d_wraddr", t), WriteAddr, tbl[t].b[2][3:0]);
      exp_b = model_pkt(tbl[t].b[1], tbl[t].b[2], tbl[t].b[3], tbl[t].b[tbl[t].n - 1], exp_wr);
      chk($sformatf("tbl%0d_errcount", t), ErrCount, 8'(model_err));
      chk($sformatf("tbl%0d_regfile", t), RegFile, model_flat());
    end

    // Stray byte in IDLE, then a write to an out-of-range address.
    send_byte(8'h33);
    idle(2);
    send_pkt({8'hA5, 8'h01, 8'h14, 8'hAA, 8'hBF}, 5, 0, got_tx, got_b, got_wr);
    exp_b = model_pkt(8'h01, 8'h14, 8'hAA, 8'hBF, exp_wr);
    chk("oob_txcount", got_tx, 1);
    chk("oob_txbyte", got_b, 8'h15);
    chk("oob_wrcount", got_wr, 0);
    chk("oob_errcount", ErrCount, 8'(model_err));
    chk("oob_regfile", RegFile, model_flat());

    // Bytes arriving during EXEC/RESP are dropped.
    tx0 = tx_n;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h05); send_byte(8'h3C); send_byte(8'h38);
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h05); send_byte(8'h07);
    idle(TX_GAP + 4);
    exp_b = model_pkt(8'h01, 8'h05, 8'h3C, 8'h38, exp_wr);
    chk("resp_drop_txcount", tx_n - tx0, 1);
    chk("resp_drop_txbyte", TXByte, 8'h06);
    chk("resp_drop_errcount", ErrCount, 8'(model_err));
    chk("resp_drop_regfile", RegFile, model_flat());

    // Inter-byte timeout: no response, one error, then normal operation.
    tx0 = tx_n;
    send_byte(8'hA5); send_byte(8'h01);
    idle(TIMEOUT + 5);
    if (model_err < 255) model_err++;
    chk("timeout_txcount", tx_n - tx0, 0);
    chk("timeout_errcount", ErrCount, 8'(model_err));
    send_pkt({8'hA5, 8'h02, 8'h05, 8'h07, 8'h00}, 4, 0, got_tx, got_b, got_wr);
    chk("after_timeout_txcount", got_tx, 1);
    chk("after_timeout_txbyte", got_b, 8'h3C);

    // A byte landing on the last allowed cycle still advances the parser.
    send_pkt({8'hA5, 8'h02, 8'h05, 8'h07, 8'h00}, 4, TIMEOUT - 1, got_tx, got_b, got_wr);
    chk("slow_txcount", got_tx, 1);
    chk("slow_txbyte", got_b, 8'h3C);
    chk("slow_errcount", ErrCount, 8'(model_err));

    for (int r = 0; r < 60; r++) begin
      case ($urandom_range(0, 3))
        0, 2:    op = 8'h01;
        1:       op = 8'h02;
        default: op = 8'($urandom);
      endcase
      addr = 8'($urandom_range(0, 19));
      data = 8'($urandom);
      sum  = (op == 8'h01) ? (op ^ addr ^ data) : (op ^ addr);
      if ($urandom_range(0, 3) == 0) sum = sum ^ 8'($urandom_range(1, 255));
      if (op == 8'h01) pk = {8'hA5, op, addr, data, sum};
      else             pk = {8'hA5, op, addr, sum, 8'h00};
      send_pkt(pk, (op == 8'h01) ? 5 : 4, -1, got_tx, got_b, got_wr);
      exp_b = model_pkt(op, addr, data, sum, exp_wr);
      chk($sformatf("rnd%0d_txcount", r), got_tx, 1);
      chk($sformatf("rnd%0d_txbyte", r), got_b, exp_b);
      chk($sformatf("rnd%0d_wrcount", r), got_wr, exp_wr);
      chk($sformatf("rnd%0d_errcount", r), ErrCount, 8'(model_err));
      chk($sformatf("rnd%0d_regfile", r), RegFile, model_flat());
    end

    // Drive the error counter past 255 with unknown-op packets.
    n_nak = 258 - model_err;
    for (int k = 0; k < n_nak; k++) begin
      send_pkt({8'hA5, 8'h09, 8'h00, 8'h09, 8'h00}, 4, 0, got_tx, got_b, got_wr);
      exp_b = model_pkt(8'h09, 8'h00, 8'h00, 8'h09, exp_wr);
    end
    chk("sat_txbyte", got_b, 8'h15);
    chk("sat_errcount", ErrCount, 8'hFF);

    // Reset mid-packet clears everything; the next packet works.
    tx0 = tx_n;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h03);
    RST = 1'b1;
    step();
    RST = 1'b0;
    model_reset();
    check_reset_state("midrst");
    idle(TX_GAP + 4);
    chk("midrst_txcount", tx_n - tx0, 0);
    send_pkt({8'hA5, 8'h01, 8'h03, 8'h5C, 8'h5E}, 5, -1, got_tx, got_b, got_wr);
    exp_b = model_pkt(8'h01, 8'h03, 8'h5C, 8'h5E, exp_wr);
    chk("postrst_txcount", got_tx, 1);
    chk("postrst_txbyte", got_b, exp_b);
    chk("postrst_wrcount", got_wr, exp_wr);
    chk("postrst_wraddr", WriteAddr, 4'd3);
    chk("postrst_regfile", RegFile, model_flat());
    chk("postrst_errcount", ErrCount, 8'(model_err));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rs232_cmd_decoder.md
# rs232_cmd_decoder

Packet-level debug command decoder downstream of the RS232 byte receiver. Consumes received bytes and their one-cycle receive strobe, parses framed read/write packets and updates a bank of 8-bit debug registers driven into the rest of the Basys design. Returns one response byte per packet through the RS232 transmitter's data/send-strobe inputs.

## Interface
- NREGS, 16: number of 8-bit debug registers; power of two, 2..256.
- ADDR_W, 4: log2(NREGS).
- TIMEOUT, 4096: idle cycles allowed between bytes of one packet.
- TX_GAP, 64: cycles held after a TXStrobe before the next may issue; must cover one full transmitter frame.
- CLK  in  1  system clock; all logic on posedge. One clock; reset is synchronous and active-high.
- RST  in  1  synchronous, active-high reset.
- RXByte  in  8  received byte, valid when RXStrobe=1.
- RXStrobe  in  1  one-cycle pulse per received byte.
- TXByte  out  8  response byte to transmitter, held stable between strobes.
- TXStrobe  out  1  one-cycle send pulse.
- RegFile  out  8*NREGS  flattened registers; reg i at [8i+7:8i].
- WriteStrobe  out  1  one-cycle pulse on each committed write.
- WriteAddr  out  ADDR_W  address of last committed write.
- ErrCount  out  8  saturating count of NAKs plus timeouts.

## Operation
- Packet: 0xA5 header, OP, ADDR, [DATA if OP=0x01], SUM.
- SUM = OP ^ ADDR ^ DATA for write; OP ^ ADDR for read.
- OP 0x01 write, 0x02 read; any other OP is still framed as a 4-byte packet (no DATA).
- States: IDLE, GET_OP, GET_ADDR, GET_DATA, GET_SUM, EXEC, RESP.
- IDLE: strobe with 0xA5 -> GET_OP; any other byte discarded silently, no error.
- GET_OP -> GET_ADDR -> (GET_DATA if write) -> GET_SUM, one transition per RXStrobe.
- GET_SUM strobe -> EXEC, latching SUM.
- EXEC (one cycle):
  - Valid write: RegFile[ADDR] <= DATA, WriteStrobe=1, WriteAddr=ADDR, TXByte=0x06 (ACK).
  - Valid read: TXByte=RegFile[ADDR].
  - Bad SUM, unknown OP, or ADDR >= NREGS: no register change, TXByte=0x15 (NAK), ErrCount+1.
  - TXStrobe=1 in all cases; -> RESP.
- RESP: count TX_GAP cycles, then -> IDLE. RXStrobe during RESP or EXEC is dropped and not counted.
- Timeout: in GET_* states, an inter-byte counter clears on every RXStrobe. Reaching TIMEOUT -> IDLE, ErrCount+1, no response.
- ErrCount saturates at 0xFF.
- Address comparison uses the full 8-bit ADDR byte; only the low ADDR_W bits index RegFile.

## Timing
- Reset values: RegFile all 0, TXByte 0x00, TXStrobe 0, WriteStrobe 0, WriteAddr 0, ErrCount 0, state IDLE, counters 0.
- RST mid-packet or mid-RESP: immediate return to IDLE on that edge; partial packet lost, registers cleared, no response.
- Latency: SUM byte sampled at edge E -> EXEC entered at E; register update, WriteStrobe, TXByte and TXStrobe visible after edge E+1 for one cycle (TXByte persists).
- Next TXStrobe earliest TX_GAP+1 cycles after the previous one.
- RXStrobe is back-to-back capable; every strobe in a GET_* state advances exactly one state.
- Timeout and RXStrobe on the same cycle: the byte wins, counter clears.

## Structure
- Package rs232_cmd_pkg: HDR=0xA5, OP_WR=0x01, OP_RD=0x02, ACK=0x06, NAK=0x15, state enum.
- Sub-module cmd_interval_timer (load/count/expired), instanced twice: inter-byte timeout and TX gap.
- Register bank, parser FSM and error counter live in rs232_cmd_decoder.

## Test plan
- Bytes A5 01 03 5C 5E (5E=01^03^5C) -> RegFile[3]=0x5C, WriteStrobe once, WriteAddr=3, TXByte=0x06 with one TXStrobe.
- After that write, A5 02 03 01 -> TXByte=0x5C, RegFile unchanged, no WriteStrobe.
- A5 01 03 5C 00 (bad SUM) -> RegFile[3] unchanged, TXByte=0x15, ErrCount=1.
- A5 01 then silence for TIMEOUT cycles -> IDLE, no TXStrobe, ErrCount+1; a following valid packet is accepted.
- Stray 0x33 in IDLE, then A5 01 14 AA with ADDR 0x14 >= 16 -> NAK, no write; strobes arriving during RESP are ignored.
- RST asserted after A5 01 03 -> outputs at reset values; a following full valid packet succeeds.
